// File: rtl/fetch_stage.sv
// RV32I instruction fetch with a single-outstanding imem handshake, one-entry skid buffer
// and IF/ID pipeline register. Define IF_PERF_CNT_EN to add fetch/bubble performance counters.
module fetch_stage #(
    parameter int             DPW       = 32,
    parameter logic [DPW-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [DPW-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stallF,
    input  logic           stallD,
    input  logic           flushD,
    input  logic           pcsrcE,
    input  logic [DPW-1:0] pctargetE,
    output logic           imem_req,
    output logic [DPW-1:0] imem_addr,
    input  logic [DPW-1:0] imem_rdata,
    input  logic           imem_ready,
    output logic [DPW-1:0] instrD,
    output logic [DPW-1:0] PCD,
    output logic [DPW-1:0] PCPlus4D,
    output logic           validD,
    output logic           fetch_busy
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]    perf_fetch_cnt,
    output logic [31:0]    perf_bubble_cnt
`endif
);

    localparam logic [DPW-1:0] PC_STEP = DPW'(4);

    typedef enum logic [1:0] {
        S_FETCH    = 2'd0,
        S_BUFFERED = 2'd1,
        S_DROP     = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [DPW-1:0] pc_reg, pc_next;
    logic [DPW-1:0] redir_reg, redir_next;
    logic [DPW-1:0] buf_instr_reg, buf_instr_next;
    logic [DPW-1:0] buf_pc_reg, buf_pc_next;

    logic [DPW-1:0] instr_reg, pcd_reg, pcplus4_reg;
    logic           valid_reg;

    logic           hold;
    logic [DPW-1:0] target;
    logic           load;
    logic [DPW-1:0] load_instr, load_pc;

    assign hold   = stallF | stallD;
    assign target = pctargetE & ~DPW'(3);

    // The buffered state is the only one without an outstanding request.
    assign imem_req   = (state_reg != S_BUFFERED) & ~rst;
    assign imem_addr  = pc_reg;
    assign fetch_busy = imem_req & ~imem_ready;

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        redir_next     = redir_reg;
        buf_instr_next = buf_instr_reg;
        buf_pc_next    = buf_pc_reg;
        load           = 1'b0;
        load_instr     = buf_instr_reg;
        load_pc        = buf_pc_reg;

        unique case (state_reg)
            S_FETCH: begin
                if (imem_ready) begin
                    if (pcsrcE) begin
                        pc_next = target;
                    end else if (!hold) begin
                        load       = 1'b1;
                        load_instr = imem_rdata;
                        load_pc    = pc_reg;
                        pc_next    = pc_reg + PC_STEP;
                    end else begin
                        buf_instr_next = imem_rdata;
                        buf_pc_next    = pc_reg;
                        pc_next        = pc_reg + PC_STEP;
                        state_next     = S_BUFFERED;
                    end
                end else if (pcsrcE) begin
                    redir_next = target;
                    state_next = S_DROP;
                end
            end
            S_BUFFERED: begin
                if (pcsrcE) begin
                    pc_next    = target;
                    state_next = S_FETCH;
                end else if (!hold) begin
                    load       = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_DROP: begin
                // The stale response must still be consumed; a redirect arriving
                // with it is the newest target and wins over the saved one.
                if (imem_ready) begin
                    pc_next    = pcsrcE ? target : redir_reg;
                    state_next = S_FETCH;
                end else if (pcsrcE) begin
                    redir_next = target;
                end
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_FETCH;
            pc_reg        <= RESET_PC;
            redir_reg     <= '0;
            buf_instr_reg <= '0;
            buf_pc_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            redir_reg     <= redir_next;
            buf_instr_reg <= buf_instr_next;
            buf_pc_reg    <= buf_pc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_reg   <= NOP_INSTR;
            pcd_reg     <= '0;
            pcplus4_reg <= '0;
            valid_reg   <= 1'b0;
        end else if (flushD) begin
            instr_reg   <= NOP_INSTR;
            pcd_reg     <= '0;
            pcplus4_reg <= '0;
            valid_reg   <= 1'b0;
        end else if (stallD) begin
            instr_reg   <= instr_reg;
        end else if (load) begin
            instr_reg   <= load_instr;
            pcd_reg     <= load_pc;
            pcplus4_reg <= load_pc + PC_STEP;
            valid_reg   <= 1'b1;
        end else begin
            instr_reg   <= NOP_INSTR;
            pcd_reg     <= '0;
            pcplus4_reg <= '0;
            valid_reg   <= 1'b0;
        end
    end

    assign instrD   = instr_reg;
    assign PCD      = pcd_reg;
    assign PCPlus4D = pcplus4_reg;
    assign validD   = valid_reg;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_reg, bubble_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (load && !flushD && !stallD) begin
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end
            if (!valid_reg && !stallD) begin
                bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_reg;
    assign perf_bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
RV32I instruction-fetch stage and IF/ID pipeline register. It sits directly upstream of execute_stage's decode path and supplies instrD and PCD. It owns the PC register and drives a single-outstanding request/ready handshake to instruction memory. A one-entry skid buffer absorbs responses that return while the hazard unit is stalling. It applies branch/jump redirects from the execute stage.

Parameters:
DPW, 32, datapath/PC/instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in instrD on reset/flush

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
stallF  in  1  hazard unit: hold PC
stallD  in  1  hazard unit: hold IF/ID register
flushD  in  1  hazard unit: replace IF/ID contents with bubble
pcsrcE  in  1  execute stage: redirect taken
pctargetE  in  DPW  execute stage: redirect target
imem_req  out  1  fetch request valid
imem_addr  out  DPW  fetch address (byte address, bits [1:0]=0)
imem_rdata  in  DPW  instruction data, valid when imem_ready=1
imem_ready  in  1  response handshake; completes the request in the same cycle
instrD  out  DPW  instruction to decode
PCD  out  DPW  PC of instrD
PCPlus4D  out  DPW  PCD+4
validD  out  1  instrD is a real instruction (0 = bubble)
fetch_busy  out  1  1 while waiting on imem (not BUFFERED); to hazard unit

Behaviour:
- Reset (async, immediate): PCF=RESET_PC, state=FETCH, instrD=NOP_INSTR, PCD=0, PCPlus4D=0, validD=0, buffer empty, redir_pc=0. imem_req=0 while rst=1.
- hold = stallF | stallD. A transfer occurs when imem_ready & imem_req.
- imem_addr=PCF except in DROP (old address held). While imem_req=1 and imem_ready=0, the address is held stable.
- FETCH, imem_req=1:
  - ready & !hold & !pcsrcE: IF/ID <= {rdata, PCF, PCF+4, valid=1}; PCF <= PCF+4. Sustains 1 instr/cycle with zero-wait memory.
  - ready & hold & !pcsrcE: buffer <= {rdata, PCF}; PCF <= PCF+4; go to BUFFERED.
  - pcsrcE & ready: discard rdata; PCF <= pctargetE; stay in FETCH.
  - pcsrcE & !ready: redir_pc <= pctargetE; go to DROP.
- BUFFERED, imem_req=0:
  - !hold & !pcsrcE: IF/ID <= buffer (valid=1); go to FETCH.
  - pcsrcE: discard buffer; PCF <= pctargetE; go to FETCH.
- DROP, imem_req=1, addr = old PCF:
  - ready: discard rdata; PCF <= redir_pc; go to FETCH.
  - A further pcsrcE while in DROP overwrites redir_pc.
- IF/ID register:
  - flushD: instrD=NOP_INSTR, validD=0, PCD/PCPlus4D=0. flushD has priority over stallD and over any load that cycle.
  - stallD & !flushD: IF/ID holds.
  - Otherwise IF/ID loads only on the events above; if nothing loads, it inserts a bubble (validD=0, instrD=NOP_INSTR).
- Priority: rst > pcsrcE > flushD (IF/ID) > hold.
- Latency: zero-wait memory gives PCF -> instrD in 1 cycle.
- PC arithmetic is modulo 2^DPW; 32'hFFFF_FFFC+4 wraps to 0. pctargetE[1:0] is forced to 0.
- Reset asserted mid-request: the request is abandoned. A late imem_ready after reset is treated as the response to RESET_PC only if it arrives while req=1.

Optional Feature:
IF_PERF_CNT_EN:
- Defined: adds outputs perf_fetch_cnt[31:0] (+1 per instruction loaded into IF/ID with validD=1) and perf_bubble_cnt[31:0] (+1 per cycle IF/ID holds a bubble and stallD=0). Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then ready tied 1, rdata=PC^32'hA5A5_0000 -> instrD sequence for PCD=0,4,8,12 on consecutive cycles; validD=1 from the 2nd edge.
- imem_ready low 3 cycles at PCF=8 -> imem_addr stable at 8, fetch_busy=1, validD=0 bubbles; then instrD loaded with PCD=8.
- stallD=stallF=1 for 2 cycles while ready=1 at PCF=16 -> BUFFERED, imem_req=0, instrD holds PCD=12; on release instrD gets the PCD=16 data, then the PCD=20 fetch follows.
- pcsrcE=1, pctargetE=32'h100 with ready=0 -> DROP; late ready data is discarded; next imem_addr=32'h100; no instruction from the old address reaches instrD.
- flushD=1 together with stallD=1 -> instrD=32'h0000_0013, validD=0; async rst pulse mid-wait -> all outputs return to reset values immediately and imem_addr=RESET_PC.
- PCF=32'hFFFF_FFFC with ready=1 -> PCPlus4D=0, next imem_addr=0; with IF_PERF_CNT_EN, perf_fetch_cnt increments by 2 across these two fetches.
